// File: rtl/prog1_pkg.sv
// prog1_pkg: shared constants, FSM states and the SECDED encoder for the Program-1 engine.
package prog1_pkg;
  localparam int NUM_MSG = 15;
  localparam logic [7:0] IN_BASE = 8'd0;
  localparam logic [7:0] OUT_BASE = 8'd30;
  localparam int MEM_DEPTH = 256;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  function automatic logic [15:0] hamming_encode(input logic [10:0] m);
    logic [11:1] d;
    logic p8, p4, p2, p1, p0;
    d = m;
    p8 = ^d[11:5];
    p4 = ^{d[11:8], d[4:2]};
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = ^{d, p8, p4, p2, p1};
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction
endpackage

// File: rtl/prog1_if.sv
// prog1_if: byte-wide memory bus between the engine (master) and the data memory (slave).
interface prog1_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic we;
  modport master (output addr, output wdata, output we, input rdata);
  modport slave (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/data_mem.sv
// data_mem: byte memory with combinational read and synchronous write; contents survive reset.
module data_mem
  import prog1_pkg::*;
(
  input logic clk,
  prog1_if.slave bus
);
  logic [7:0] core [0:MEM_DEPTH-1];
  always_ff @(posedge clk)
    if (bus.we) core[bus.addr] <= bus.wdata;
  assign bus.rdata = core[bus.addr];
endmodule

// File: rtl/top_level.sv
// top_level: encodes NUM_MSG 11-bit messages into 16-bit SECDED codewords, one message every four cycles.
module top_level
  import prog1_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);
  prog1_if bus();
  state_t state, nxt;
  logic [3:0] cnt;
  logic [7:0] lo;
  logic [2:0] hi;
  logic [15:0] cw;
  logic [7:0] off;
  data_mem dm1 (.clk(clk), .bus(bus.slave));
  assign off = {3'b000, cnt, 1'b0};
  assign cw = hamming_encode({hi, lo});
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      lo <= '0;
      hi <= '0;
    end else begin
      state <= nxt;
      done <= (nxt == DONE);
      if (state == RD_LO) lo <= bus.rdata;
      if (state == RD_HI) hi <= bus.rdata[2:0];
      if (state == WR_HI && nxt == RD_LO) cnt <= cnt + 4'd1;
    end
  always_comb begin
    nxt = state;
    bus.addr = '0;
    bus.we = 1'b0;
    bus.wdata = '0;
    case (state)
      IDLE: nxt = RD_LO;
      RD_LO: begin
        bus.addr = IN_BASE + off;
        nxt = RD_HI;
      end
      RD_HI: begin
        bus.addr = IN_BASE + off + 8'd1;
        nxt = WR_LO;
      end
      WR_LO: begin
        bus.addr = OUT_BASE + off;
        bus.we = 1'b1;
        bus.wdata = cw[7:0];
        nxt = WR_HI;
      end
      WR_HI: begin
        bus.addr = OUT_BASE + off + 8'd1;
        bus.we = 1'b1;
        bus.wdata = cw[15:8];
        nxt = (cnt == 4'(NUM_MSG - 1)) ? DONE : RD_LO;
      end
      default: nxt = DONE;
    endcase
  end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: directed checks of the SECDED block encoder against hand values and a positional Hamming model.
module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;
  int checks = 0;
  int errors = 0;
  int e;
  logic [7:0] img [256];
  logic [10:0] msg [15];
  logic [15:0] c0;

  always #5 clk = ~clk;

  top_level dut (.clk(clk), .reset(reset), .done(done));

  // Generic Hamming: data fills non-power-of-two positions, parity bit k covers positions with bit k set.
  function automatic logic [15:0] ref_enc(input logic [10:0] m);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 3; p < 16; p++)
      if (p != 4 && p != 8) begin
        c[p] = m[k];
        k++;
      end
    for (int b = 0; b < 4; b++)
      for (int p = 1; p < 16; p++)
        if (p != (1 << b) && ((p >> b) & 1) == 1) c[1 << b] = c[1 << b] ^ c[p];
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input int i, input logic [7:0] lo, input logic [7:0] hi);
    img[2*i] = lo;
    img[2*i+1] = hi;
    msg[i] = {hi[2:0], lo};
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
    for (int i = 0; i < 15; i++) msg[i] = {img[2*i+1][2:0], img[2*i]};
  endtask

  task automatic write_mem();
    for (int a = 0; a < 256; a++) dut.dm1.core[a] <= img[a];
    #1;
  endtask

  task automatic run(output int edges);
    @(negedge clk) reset = 1'b1;
    edges = -1;
    for (int n = 1; n <= 200 && edges < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) edges = n;
    end
  endtask

  task automatic verify_out(input string tag);
    int bad;
    logic [15:0] c;
    for (int i = 0; i < 15; i++) begin
      c = ref_enc(msg[i]);
      check({tag, "_lo"}, {24'd0, dut.dm1.core[30+2*i]}, {24'd0, c[7:0]});
      check({tag, "_hi"}, {24'd0, dut.dm1.core[31+2*i]}, {24'd0, c[15:8]});
    end
    bad = 0;
    for (int a = 0; a < 256; a++)
      if ((a < 30 || a >= 60) && dut.dm1.core[a] !== img[a]) bad++;
    check({tag, "_untouched"}, bad, 0);
  endtask

  initial begin
    #2;
    check("reset_done", {31'd0, done}, 0);
    fill_random();
    for (int i = 0; i < 15; i++) set_msg(i, 8'h00, 8'h00);
    write_mem();
    run(e);
    check("zero_latency", e, 61);
    check("zero_byte30", {24'd0, dut.dm1.core[30]}, 0);
    check("zero_byte59", {24'd0, dut.dm1.core[59]}, 0);
    verify_out("zero");

    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_clear", {31'd0, done}, 0);
    fill_random();
    set_msg(0, 8'hFF, 8'h07);
    set_msg(1, 8'h01, 8'h00);
    set_msg(2, 8'h00, 8'h04);
    set_msg(3, 8'h00, 8'hFC);
    write_mem();
    run(e);
    check("dir_latency", e, 61);
    check("all_ones_lo", {24'd0, dut.dm1.core[30]}, 32'hFF);
    check("all_ones_hi", {24'd0, dut.dm1.core[31]}, 32'hFF);
    check("d1_lo", {24'd0, dut.dm1.core[32]}, 32'h0F);
    check("d1_hi", {24'd0, dut.dm1.core[33]}, 32'h00);
    check("d11_lo", {24'd0, dut.dm1.core[34]}, 32'h17);
    check("d11_hi", {24'd0, dut.dm1.core[35]}, 32'h81);
    check("junk_lo", {24'd0, dut.dm1.core[36]}, 32'h17);
    check("junk_hi", {24'd0, dut.dm1.core[37]}, 32'h81);
    verify_out("dir");
    repeat (10) @(posedge clk);
    #1 check("done_hold", {31'd0, done}, 1);
    verify_out("hold");

    @(posedge clk);
    #3 reset = 1'b0;
    fill_random();
    write_mem();
    c0 = ref_enc(msg[0]);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("midrun_done", {31'd0, done}, 0);
    reset = 1'b0;
    #1 check("midrun_reset_done", {31'd0, done}, 0);
    check("partial_lo", {24'd0, dut.dm1.core[30]}, {24'd0, c0[7:0]});
    check("partial_hi", {24'd0, dut.dm1.core[31]}, {24'd0, c0[15:8]});
    run(e);
    check("rerun_latency", e, 61);
    verify_out("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
